// File: rtl/up_counter_checker.sv
// up_counter_checker: receive-side checker for an incrementing counter stream.
// Seeks onto the sequence, acquires lock after LOCK_LEN consecutive correct
// increments, then flags every accepted sample that is not previous+1.
// Optional feature macro: CHECKER_WRAP_CNT_EN enables the wrap_count statistic;
// when undefined, wrap_count is tied to zero.
module up_counter_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_LEN   = 4,
    parameter int MISS_LIMIT = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             valid_in,
    input  logic             clear_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count
);

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_LEN_C   = 4'(LOCK_LEN);
    localparam logic [3:0]       MISS_LIMIT_C = 4'(MISS_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       miss_q, miss_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             wrap_hit;
    logic [WIDTH-1:0] sample_p1;

    assign sample_p1 = sample_in + WIDTH'(1);

    // Next-state logic for the lock FSM, expected value and run/miss counters.
    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path
        // through the case leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        exp_d       = exp_q;
        run_d       = run_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        wrap_hit    = 1'b0;
        if (valid_in) begin
            unique case (state_q)
                SEEK: begin
                    exp_d   = sample_p1;
                    run_d   = 4'd0;
                    state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    exp_d = sample_p1;
                    if (sample_in == exp_q) begin
                        run_d = run_q + 4'd1;
                        if (run_q + 4'd1 == LOCK_LEN_C) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
                LOCKED: begin
                    exp_d = sample_p1;
                    if (sample_in == exp_q) begin
                        miss_d   = 4'd0;
                        // A match against an expected 0 means all-ones -> 0.
                        wrap_hit = (exp_q == '0);
                    end else begin
                        err_pulse_d = 1'b1;
                        miss_d      = miss_q + 4'd1;
                        if (miss_q + 4'd1 == MISS_LIMIT_C) begin
                            state_d = SEEK;
                        end
                    end
                end
                default: state_d = SEEK;
            endcase
        end
    end

    assign locked_d = (state_d == LOCKED);

    // Saturating error counter; clear takes priority over a same-edge error.
    always_comb begin
        err_count_d = err_count_q;
        if (clear_in) begin
            err_count_d = '0;
        end else if (err_pulse_d && err_count_q != CNT_MAX) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    // State, counter and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // flops sample the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= SEEK;
            exp_q       <= '0;
            run_q       <= 4'd0;
            miss_q      <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

`ifdef CHECKER_WRAP_CNT_EN
    logic [CNT_W-1:0] wrap_count_q, wrap_count_d;

    // Saturating count of all-ones -> 0 transitions seen while locked.
    always_comb begin
        wrap_count_d = wrap_count_q;
        if (clear_in) begin
            wrap_count_d = '0;
        end else if (wrap_hit && wrap_count_q != CNT_MAX) begin
            wrap_count_d = wrap_count_q + CNT_W'(1);
        end
    end

    // Wrap counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_count_q <= '0;
        end else begin
            wrap_count_q <= wrap_count_d;
        end
    end

    assign wrap_count = wrap_count_q;
`else
    logic unused_wrap;
    assign unused_wrap = wrap_hit;
    assign wrap_count  = '0;
`endif

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_up_counter_checker.sv
// Directed, table-driven bench for up_counter_checker (WIDTH 8, LOCK_LEN 4,
// MISS_LIMIT 3, CNT_W 8). Honours CHECKER_WRAP_CNT_EN for wrap expectations.
module tb_up_counter_checker;

`ifdef CHECKER_WRAP_CNT_EN
    localparam int WRAP_EN = 1;
`else
    localparam int WRAP_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] sample_in = '0;
    logic       valid_in = 1'b0;
    logic       clear_in = 1'b0;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [7:0] wrap_count;

    int n_vec = 0;
    int n_bad = 0;

    up_counter_checker #(
        .WIDTH(8), .LOCK_LEN(4), .MISS_LIMIT(3), .CNT_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_in (sample_in),
        .valid_in  (valid_in),
        .clear_in  (clear_in),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .wrap_count(wrap_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       valid;
        logic       clear;
        logic [7:0] sample;
        logic       e_locked;
        logic       e_pulse;
        logic [7:0] e_err;
        logic [7:0] e_wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic v, input logic c,
                                input logic [7:0] s, input logic el,
                                input logic ep, input int ee, input int ew);
        vec_t t;
        t.rst = r; t.valid = v; t.clear = c; t.sample = s;
        t.e_locked = el; t.e_pulse = ep;
        t.e_err = 8'(ee); t.e_wrap = 8'(ew);
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input int idx, input int act,
                         input int req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, req);
        end
    endtask

    // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic tick(input logic r, input logic v, input logic c,
                        input logic [7:0] s);
        rst = r; valid_in = v; clear_in = c; sample_in = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] e;
        int ec_m;
        int wc_m;

        // Reset and first lock: 0..4, lock after the 5th sample.
        add(1, 0, 0, 8'd0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 8'(i), 0, 0, 0, 0);
        add(0, 1, 0, 8'd4, 1, 0, 0, 0);
        // Locked stream up to 11, then skip 12: one error on 13, 14 matches.
        for (int i = 5; i <= 11; i++) add(0, 1, 0, 8'(i), 1, 0, 0, 0);
        add(0, 1, 0, 8'd13, 1, 1, 1, 0);
        add(0, 1, 0, 8'd14, 1, 0, 1, 0);
        // Walk up through 254, 255 and wrap to 0, 1.
        for (int i = 15; i <= 255; i++) add(0, 1, 0, 8'(i), 1, 0, 1, 0);
        add(0, 1, 0, 8'd0, 1, 0, 1, WRAP_EN);
        add(0, 1, 0, 8'd1, 1, 0, 1, WRAP_EN);
        // Five idle cycles with garbage on the sample bus.
        add(0, 0, 0, 8'h77, 1, 0, 1, WRAP_EN);
        add(0, 0, 0, 8'h00, 1, 0, 1, WRAP_EN);
        add(0, 0, 0, 8'hFF, 1, 0, 1, WRAP_EN);
        add(0, 0, 0, 8'h01, 1, 0, 1, WRAP_EN);
        add(0, 0, 0, 8'hA5, 1, 0, 1, WRAP_EN);
        add(0, 1, 0, 8'd2, 1, 0, 1, WRAP_EN);
        add(0, 1, 0, 8'd3, 1, 0, 1, WRAP_EN);
        add(0, 1, 0, 8'd4, 1, 0, 1, WRAP_EN);
        // Error then an idle cycle: pulse must drop, resync to 7.
        add(0, 1, 0, 8'd6, 1, 1, 2, WRAP_EN);
        add(0, 0, 0, 8'd9, 1, 0, 2, WRAP_EN);
        add(0, 1, 0, 8'd7, 1, 0, 2, WRAP_EN);
        // Stuck at 50: three errors drop lock; reseed at 50, relock on 54.
        add(0, 1, 0, 8'd50, 1, 1, 3, WRAP_EN);
        add(0, 1, 0, 8'd50, 1, 1, 4, WRAP_EN);
        add(0, 1, 0, 8'd50, 0, 1, 5, WRAP_EN);
        add(0, 1, 0, 8'd50, 0, 0, 5, WRAP_EN);
        add(0, 1, 0, 8'd51, 0, 0, 5, WRAP_EN);
        add(0, 1, 0, 8'd52, 0, 0, 5, WRAP_EN);
        add(0, 1, 0, 8'd53, 0, 0, 5, WRAP_EN);
        add(0, 1, 0, 8'd54, 1, 0, 5, WRAP_EN);
        add(0, 1, 0, 8'd55, 1, 0, 5, WRAP_EN);
        // Clear on the same edge as an error: pulse fires, counts end at 0.
        add(0, 1, 1, 8'd57, 1, 1, 0, 0);
        add(0, 1, 0, 8'd58, 1, 0, 0, 0);
        add(0, 1, 0, 8'd60, 1, 1, 1, 0);
        // Reset while locked with a pending valid sample.
        add(1, 1, 0, 8'd61, 0, 0, 0, 0);
        // Stuck all-ones and all-zeros streams never lock.
        for (int i = 0; i < 8; i++) add(0, 1, 0, 8'hFF, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 1, 0, 8'h00, 0, 0, 0, 0);
        // Reset mid-acquire (run 2), then the full LOCK_LEN+1 samples again.
        add(1, 0, 0, 8'd0, 0, 0, 0, 0);
        add(0, 1, 0, 8'd0, 0, 0, 0, 0);
        add(0, 1, 0, 8'd1, 0, 0, 0, 0);
        add(0, 1, 0, 8'd2, 0, 0, 0, 0);
        add(1, 1, 1, 8'd3, 0, 0, 0, 0);
        for (int i = 3; i <= 6; i++) add(0, 1, 0, 8'(i), 0, 0, 0, 0);
        add(0, 1, 0, 8'd7, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].valid, vecs[i].clear, vecs[i].sample);
            check("locked",     i, int'(locked),     int'(vecs[i].e_locked));
            check("err_pulse",  i, int'(err_pulse),  int'(vecs[i].e_pulse));
            check("err_count",  i, int'(err_count),  int'(vecs[i].e_err));
            check("wrap_count", i, int'(wrap_count), int'(vecs[i].e_wrap));
        end

        // Saturation: alternate error / match so lock holds while errors pile up.
        e    = 8'd8;
        ec_m = 0;
        wc_m = 0;
        for (int k = 0; k < 270; k++) begin
            tick(0, 1, 0, e + 8'd1);
            if (ec_m < 255) ec_m++;
            check("sat_pulse", k, int'(err_pulse), 1);
            check("sat_count", k, int'(err_count), ec_m);
            e = e + 8'd2;
            tick(0, 1, 0, e);
            if (e == 8'd0 && WRAP_EN != 0) wc_m++;
            check("sat_locked", k, int'(locked), 1);
            e = e + 8'd1;
        end
        check("sat_final", 0, int'(err_count), 255);
        check("sat_wrap", 0, int'(wrap_count), wc_m);

        // clear_in alone: counts to 0, lock unaffected.
        tick(0, 0, 1, 8'h00);
        check("clr_err",    0, int'(err_count),  0);
        check("clr_wrap",   0, int'(wrap_count), 0);
        check("clr_locked", 0, int'(locked),     1);
        check("clr_pulse",  0, int'(err_pulse),  0);
        tick(0, 1, 0, e);
        check("post_clr_match", 0, int'(err_pulse), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/up_counter_checker.md
# up_counter_checker

Receive-side checker for the free-running up-counter stream. Samples an incrementing WIDTH-bit value each valid cycle, acquires lock on the sequence, then flags every sample that is not previous+1 (mod 2^WIDTH). Sits on the board/test side of the counter output pins. Reports lock state, per-sample error pulses and saturating error/wrap statistics.

## Interface
- WIDTH, 8: sample width; wrap-around is modulo 2^WIDTH.
- LOCK_LEN, 4: consecutive correct increments required to declare lock (1..15).
- MISS_LIMIT, 3: consecutive mismatches while locked that drop lock (1..15).
- CNT_W, 8: width of err_count and wrap_count.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- sample_in  in  WIDTH  counter value under test.
- valid_in  in  1  sample_in is meaningful this cycle; when low, the cycle is ignored entirely.
- clear_in  in  1  synchronous clear of err_count and wrap_count only; state and lock unaffected.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle pulse: the previous accepted sample mismatched while LOCKED.
- err_count  out  CNT_W  saturating count of err_pulse events.
- wrap_count  out  CNT_W  saturating count of observed all-ones to zero transitions while LOCKED.

## Operation
- State machine: SEEK, ACQUIRE, LOCKED. Internal: expect (WIDTH), run (4 b), miss (4 b).
- Accepted sample = valid_in high on a clock edge, rst low. Non-accepted cycles hold all state; err_pulse goes low.
- SEEK: on accepted sample, expect <= sample+1, run <= 0, go ACQUIRE.
- ACQUIRE: sample == expect: run+1, expect <= sample+1; when run+1 == LOCK_LEN go LOCKED, miss <= 0. Mismatch: re-seed expect <= sample+1, run <= 0, stay ACQUIRE. No errors counted in ACQUIRE.
- LOCKED, match: miss <= 0, expect <= sample+1. If the prior expected value was 0 (i.e. sample == 0 following all-ones), wrap_count+1.
- LOCKED, mismatch: err_pulse, err_count+1, miss+1, expect <= sample+1 (resync to new value). When miss+1 == MISS_LIMIT go SEEK; err_pulse still fires for that sample.
- expect arithmetic is WIDTH-bit, wrap silent: all-ones+1 = 0 is a match.
- Counters saturate at 2^CNT_W-1; no wrap.
- clear_in and an error on the same edge: clear wins, count ends at 0 (the pulse still fires).
- Constant / stuck streams (e.g. all-zeros or all-ones with valid high) never lock; if locked, they drop lock after MISS_LIMIT samples.

## Timing
- All outputs registered; none combinational from inputs.
- err_pulse high for exactly the cycle after the edge that accepted the bad sample; err_count updated on that same edge.
- locked rises in the cycle after the edge accepting the LOCK_LEN-th consecutive match; minimum LOCK_LEN+1 accepted samples from SEEK.
- locked falls in the cycle after the edge accepting the MISS_LIMIT-th consecutive mismatch.
- rst (any time, including mid-acquire): state SEEK, expect 0, run 0, miss 0, locked 0, err_pulse 0, err_count 0, wrap_count 0 after the edge. rst overrides valid_in and clear_in.
- Gaps in valid_in do not break lock or run counts.

## Configuration
- CHECKER_WRAP_CNT_EN defined: wrap_count logic present as described.
- Not defined: no wrap detection logic; wrap_count tied to 0; all other behaviour identical.

## Test plan
- Reset, then valid_in high with sample 0,1,2,3,4 -> locked rises the cycle after sample 4; err_count 0.
- Locked, feed 10,11,13,14 -> single err_pulse the cycle after 13; err_count 1; locked stays 1; 14 accepted as match.
- Locked, feed 254,255,0,1 -> no err_pulse; wrap_count 1 with macro, 0 without.
- Locked, feed 50,50,50,50 -> err_pulse on 3 samples, err_count 3, locked falls after the third; subsequent 51..55 relock after 5th.
- Insert valid_in low for 5 cycles with garbage sample_in mid-stream -> no state change, no pulse; err_count saturates at 255 under a continuous error stream with forced relock, clear_in returns it to 0.
- Assert rst during ACQUIRE with run 2 -> all outputs 0 next cycle; lock needs full LOCK_LEN+1 samples again.
